// File: rtl/fsk_symbol_framer.sv
// -----------------------------------------------------------------------------
// fsk_symbol_framer
//
// Feeds an 8-FSK modulator. Bytes are buffered in a small FIFO, split MSB-first
// into 3-bit symbols and presented on sym_out. Each frame produces one start
// pulse, a SYNC_CYCLES gap that lines up with the modulator's sync burst, and
// then one symbol every SYMBOL_CYCLES clocks until the frame's last byte is used
// up. A short tail (1 or 2 bits) is zero-padded on the LSB side.
//
// Optional build macro:
//   FSK_GRAY_MAP_EN  when defined, sym_out carries the Gray code of the symbol
//                    (b ^ (b >> 1)); otherwise natural binary. Timing is
//                    identical in both builds.
//
// Parameters:
//   SYMBOL_CYCLES  clocks each symbol is held on sym_out (>= 2)
//   SYNC_CYCLES    clocks from the start pulse to the first symbol
//   FIFO_AW        FIFO address width, depth = 2**FIFO_AW entries
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   s_data      input byte
//   s_valid     s_data / s_last valid
//   s_last      byte is the last of its frame
//   s_ready     FIFO can accept a byte this cycle
//   sym_out     symbol to the modulator data_in
//   start       one-cycle pulse at frame begin
//   busy        high while a frame is in SYNC or DATA
//   frame_done  one-cycle pulse after the final symbol period of a frame
//   underrun    one-cycle pulse when a pad symbol is inserted mid-frame
// -----------------------------------------------------------------------------
module fsk_symbol_framer #(
   parameter int SYMBOL_CYCLES = 64,
   parameter int SYNC_CYCLES   = 11,
   parameter int FIFO_AW       = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [2:0] sym_out,
   output logic       start,
   output logic       busy,
   output logic       frame_done,
   output logic       underrun
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TMAX  = (SYMBOL_CYCLES > SYNC_CYCLES) ? SYMBOL_CYCLES : SYNC_CYCLES;
   localparam int TW    = $clog2(TMAX);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SYNC = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic [FIFO_AW:0]   FULL_COUNT  = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW:0]   COUNT_ONE   = 1;
   localparam logic [FIFO_AW-1:0] PTR_ONE     = 1;
   localparam logic [TW-1:0]      TIMER_ONE   = 1;
   localparam logic [TW-1:0]      SYNC_LAST   = TW'(SYNC_CYCLES - 1);
   localparam logic [TW-1:0]      SYMBOL_LAST = TW'(SYMBOL_CYCLES - 1);

   // ---------------------------------------------------------------- FIFO
   logic [8:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   count;
   logic [8:0]         rd_entry;
   logic               fifo_empty;
   logic               push;
   logic               do_pop;

   assign s_ready    = (count != FULL_COUNT);
   assign fifo_empty = (count == '0);
   assign push       = s_valid && s_ready;
   assign rd_entry   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, do_pop})
            2'b10:   count <= count + COUNT_ONE;
            2'b01:   count <= count - COUNT_ONE;
            default: ;
         endcase
      end
   end

   // NOTE: storage has no reset; emptiness is tracked by count, so stale
   // contents are never observed and the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {s_last, s_data};
   end

   // ---------------------------------------------------- framing state
   logic [1:0]    state;
   logic [TW-1:0] timer;
   logic [9:0]    bit_buf;    // valid bits left-aligned, unused bits kept zero
   logic [3:0]    cnt;        // number of valid bits in bit_buf, 0..10
   logic          last_seen;  // this frame's last byte has been popped
   logic          boundary;
   logic [9:0]    merged;

   function automatic logic [2:0] map_symbol(input logic [2:0] b);
`ifdef FSK_GRAY_MAP_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   assign busy = (state != ST_IDLE);

   // NOTE: every signal gets a value before any condition so this block
   // stays purely combinational and no latch is inferred.
   always_comb begin
      boundary = 1'b0;
      if (state == ST_SYNC)      boundary = (timer == SYNC_LAST);
      else if (state == ST_DATA) boundary = (timer == SYMBOL_LAST);
      // A byte is only fetched when fewer than 3 bits remain and the frame
      // has not yet consumed its last byte; bytes beyond it wait for the
      // next frame.
      do_pop = boundary && (cnt < 4'd3) && !last_seen && !fifo_empty;
      // With cnt <= 2 the new byte lands directly below the remaining bits.
      merged = bit_buf | ({rd_entry[7:0], 2'b00} >> cnt);
   end

   // NOTE: registered state uses non-blocking assignments so every update in
   // this block sees the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         timer      <= '0;
         bit_buf    <= '0;
         cnt        <= '0;
         last_seen  <= 1'b0;
         sym_out    <= 3'd0;
         start      <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         start      <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         case (state)
            ST_IDLE: begin
               sym_out <= 3'd0;
               if (!fifo_empty) begin
                  state <= ST_SYNC;
                  start <= 1'b1;
                  timer <= '0;
               end
            end
            ST_SYNC, ST_DATA: begin
               if (!boundary) begin
                  timer <= timer + TIMER_ONE;
               end else begin
                  timer <= '0;
                  state <= ST_DATA;
                  if (cnt >= 4'd3) begin
                     sym_out <= map_symbol(bit_buf[9:7]);
                     bit_buf <= bit_buf << 3;
                     cnt     <= cnt - 4'd3;
                  end else if (do_pop) begin
                     sym_out   <= map_symbol(merged[9:7]);
                     bit_buf   <= merged << 3;
                     cnt       <= cnt + 4'd5;
                     last_seen <= rd_entry[8];
                  end else if (!last_seen) begin
                     // Source fell behind: hold the buffered bits, send a pad.
                     sym_out  <= 3'd0;
                     underrun <= 1'b1;
                  end else if (cnt != 4'd0) begin
                     // Tail of the frame: remaining bits, zero-filled below.
                     sym_out <= map_symbol(bit_buf[9:7]);
                     bit_buf <= '0;
                     cnt     <= '0;
                  end else begin
                     sym_out    <= 3'd0;
                     frame_done <= 1'b1;
                     last_seen  <= 1'b0;
                     state      <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
